// File: rtl/fpu_sched_pkg.sv
// Shared types and constants for the add/sub pipe scheduler.
//   fp_word_t  : one single-precision word
//   issue_t    : everything the shared pipe needs for one operation
//   RM_*       : rounding-mode encodings carried on fu_rmode
//   id_width() : bits needed to name one of n requesters
package fpu_sched_pkg;

   typedef logic [31:0] fp_word_t;

   typedef struct packed {
      fp_word_t   opa;
      fp_word_t   opb;
      logic       add;
      logic [1:0] rmode;
   } issue_t;

   localparam logic [1:0] RM_NEAREST = 2'd0;
   localparam logic [1:0] RM_ZERO    = 2'd1;
   localparam logic [1:0] RM_POS_INF = 2'd2;
   localparam logic [1:0] RM_NEG_INF = 2'd3;

   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fpu_rsp_fifo.sv
// Per-requester response queue.
//   clk, reset      : clock, async active-low reset
//   push, din       : write one result (ignored only if full and not popping)
//   pop, dout       : dout is the head; pop removes it when not empty
//   empty/full/count: occupancy
// Push and pop in the same cycle are legal in every state.
module fpu_rsp_fifo #(
   parameter  int DEPTH = 2,
   parameter  int WIDTH = 32,
   localparam int CW    = $clog2(DEPTH + 1),
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A pop frees the head slot in the same edge, so push-while-full is fine then.
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   // NOTE: the storage array has no reset; valid data is tracked by the
   // pointers and count, so resetting the payload would only cost flops.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // NOTE: state registers use non-blocking assignments so every flop sees
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
      !(push && full && !pop));

endmodule

// File: rtl/fpu_addsub_sched.sv
// Scheduler sharing one fixed-latency add/sub pipe among NREQ requesters.
//   req_*    : per-requester request channel (valid/ready, packed operand fields)
//   rsp_*    : per-requester response channel (valid/ready, head of its queue)
//   drain    : stop granting new requests; in-flight work still completes
//   idle     : nothing issued, nothing in the pipe, all queues empty
//   fu_*     : issue register toward the shared pipe, fu_result back from it
// Credits bound outstanding+queued results per requester to CRED, so the
// non-stallable pipe can always deliver into the response queue.
module fpu_addsub_sched
   import fpu_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int LAT  = 4,
   parameter int CRED = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*32-1:0] req_opa,
   input  logic [NREQ*32-1:0] req_opb,
   input  logic [NREQ-1:0]   req_add,
   input  logic [NREQ*2-1:0] req_rmode,
   output logic [NREQ-1:0]   rsp_valid,
   input  logic [NREQ-1:0]   rsp_ready,
   output logic [NREQ*32-1:0] rsp_data,
   input  logic              drain,
   output logic              idle,
   output logic              fu_valid,
   output fp_word_t          fu_opa,
   output fp_word_t          fu_opb,
   output logic              fu_add,
   output logic [1:0]        fu_rmode,
   input  fp_word_t          fu_result
);

   localparam int IDW = id_width(NREQ);
   localparam int CW  = $clog2(CRED + 1);

   logic [IDW-1:0]  ptr, grant_id, fu_id;
   logic            grant;
   issue_t          win;
   logic [NREQ-1:0] eligible, push, pop, empty, full;
   logic [CW-1:0]   credit     [NREQ];
   logic [CW-1:0]   fifo_count [NREQ];
   logic [LAT-1:0]  tag_v;
   logic [IDW-1:0]  tag_id     [LAT];

   for (genvar i = 0; i < NREQ; i++) begin : g_elig
      assign eligible[i] = req_valid[i] & (credit[i] < CW'(CRED)) & ~drain;
   end

   // Round-robin search starting one past the last winner.
   // NOTE: every output of this block gets a default first so no path
   // leaves a value unassigned and infers a latch.
   always_comb begin
      req_ready = '0;
      grant     = 1'b0;
      grant_id  = ptr;
      for (int k = 1; k <= NREQ; k++) begin
         if (!grant && eligible[(int'(ptr) + k) % NREQ]) begin
            grant    = 1'b1;
            grant_id = IDW'((int'(ptr) + k) % NREQ);
         end
      end
      if (grant) req_ready[grant_id] = 1'b1;
      win.opa   = req_opa[32*grant_id +: 32];
      win.opb   = req_opb[32*grant_id +: 32];
      win.add   = req_add[grant_id];
      win.rmode = req_rmode[2*grant_id +: 2];
   end

   // Issue register and arbitration pointer; fu data holds when idle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr      <= IDW'(NREQ - 1);
         fu_valid <= 1'b0;
         fu_id    <= '0;
         fu_opa   <= '0;
         fu_opb   <= '0;
         fu_add   <= 1'b0;
         fu_rmode <= RM_NEAREST;
      end else begin
         fu_valid <= grant;
         if (grant) begin
            ptr      <= grant_id;
            fu_id    <= grant_id;
            fu_opa   <= win.opa;
            fu_opb   <= win.opb;
            fu_add   <= win.add;
            fu_rmode <= win.rmode;
         end
      end
   end

   // Tag pipe mirrors the shared pipe so the last stage names the owner of
   // fu_result. Clearing it on reset drops results of pre-reset issues.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tag_v <= '0;
         for (int k = 0; k < LAT; k++) tag_id[k] <= '0;
      end else begin
         tag_v[0]  <= fu_valid;
         tag_id[0] <= fu_id;
         for (int k = 1; k < LAT; k++) begin
            tag_v[k]  <= tag_v[k-1];
            tag_id[k] <= tag_id[k-1];
         end
      end
   end

   // Credits count results owed to each requester: in flight plus queued.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREQ; i++) credit[i] <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            case ({grant && (grant_id == IDW'(i)), pop[i]})
               2'b10:   credit[i] <= credit[i] + 1'b1;
               2'b01:   credit[i] <= credit[i] - 1'b1;
               default: credit[i] <= credit[i];
            endcase
         end
      end
   end

   for (genvar i = 0; i < NREQ; i++) begin : g_q
      assign push[i] = tag_v[LAT-1] && (tag_id[LAT-1] == IDW'(i));
      assign pop[i]  = ~empty[i] & rsp_ready[i];

      fpu_rsp_fifo #(.DEPTH(CRED), .WIDTH(32)) u_fifo (
         .clk   (clk),
         .reset (reset),
         .push  (push[i]),
         .din   (fu_result),
         .pop   (pop[i]),
         .dout  (rsp_data[32*i +: 32]),
         .empty (empty[i]),
         .full  (full[i]),
         .count (fifo_count[i])
      );

      a_credit_bound: assert property (@(posedge clk) disable iff (!reset)
         (credit[i] <= CW'(CRED)) && (fifo_count[i] <= credit[i]));
      a_push_room: assert property (@(posedge clk) disable iff (!reset)
         !(push[i] && full[i] && !pop[i]));
   end

   assign rsp_valid = ~empty;
   assign idle      = ~|tag_v & ~fu_valid & (&empty);

endmodule

// File: tb/tb_fpu_addsub_sched.sv
// Directed self-checking bench for fpu_addsub_sched with a behavioural
// LAT-cycle pipe model and a per-requester expected-result scoreboard.
module tb_fpu_addsub_sched;
   import fpu_sched_pkg::*;

   localparam int NREQ = 4;
   localparam int LAT  = 4;
   localparam int CRED = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic [NREQ-1:0]   req_valid, req_ready, req_add;
   logic [NREQ*32-1:0] req_opa, req_opb, rsp_data;
   logic [NREQ*2-1:0] req_rmode;
   logic [NREQ-1:0]   rsp_valid, rsp_ready;
   logic              drain, idle, fu_valid, fu_add;
   logic [31:0]       fu_opa, fu_opb, fu_result;
   logic [1:0]        fu_rmode;

   int n_checks = 0, n_pass = 0, n_pops = 0, seq = 0;
   logic [31:0] exp_q [NREQ][$];
   logic [31:0] pm [LAT];

   always #5 clk = ~clk;

   fpu_addsub_sched #(.NREQ(NREQ), .LAT(LAT), .CRED(CRED)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_opa(req_opa), .req_opb(req_opb), .req_add(req_add), .req_rmode(req_rmode),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .drain(drain), .idle(idle),
      .fu_valid(fu_valid), .fu_opa(fu_opa), .fu_opb(fu_opb),
      .fu_add(fu_add), .fu_rmode(fu_rmode), .fu_result(fu_result)
   );

   // Stand-in for the arithmetic: the one documented case plus a tagging hash.
   function automatic logic [31:0] pipe_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic add, input logic [1:0] rm);
      if (a == 32'h3F80_0000 && b == 32'h4000_0000 && add && rm == RM_NEAREST)
         return 32'h4040_0000;
      return a ^ {b[15:0], b[31:16]} ^ {29'd0, add, rm};
   endfunction

   // Pipe samples fu_* at an edge and presents the result LAT-1 edges later,
   // so it is written to the queue on the LAT-th edge after sampling.
   always @(posedge clk) begin
      pm[0] <= fu_valid ? pipe_fn(fu_opa, fu_opb, fu_add, fu_rmode) : 32'hDEAD_BEEF;
      for (int k = 1; k < LAT; k++) pm[k] <= pm[k-1];
   end
   assign fu_result = pm[LAT-1];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
      else n_pass++;
   endtask

   // Scoreboard: accepted requests enqueue their expected result, pops compare.
   always @(negedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NREQ; i++) exp_q[i].delete();
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i])
               exp_q[i].push_back(pipe_fn(req_opa[32*i +: 32], req_opb[32*i +: 32],
                                          req_add[i], req_rmode[2*i +: 2]));
            if (rsp_valid[i] && rsp_ready[i]) begin
               n_pops++;
               if (exp_q[i].size() > 0) check("rsp_data", rsp_data[32*i +: 32], exp_q[i].pop_front());
               else check("rsp_spurious", 32'(rsp_valid[i]), 32'd0);
            end
         end
      end
   end

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic add, input logic [1:0] rm);
      req_opa[32*i +: 32] = a;
      req_opb[32*i +: 32] = b;
      req_add[i]          = add;
      req_rmode[2*i +: 2] = rm;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One cycle: sample at negedge, cross the edge, refresh the winner's operand.
   task automatic step(output int gid, output logic fv, output logic [NREQ-1:0] rdy);
      @(negedge clk);
      gid = -1;
      fv  = fu_valid;
      rdy = req_ready;
      for (int i = 0; i < NREQ; i++) if (req_valid[i] && req_ready[i]) gid = i;
      tick();
      if (gid >= 0) begin
         seq++;
         req_opa[32*gid +: 32] = {8'(gid), 24'(seq)};
      end
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      @(negedge clk);
      while (!idle && n < 100) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(idle), 32'd1);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int g, n, exp_g, n1, others, pops0;
      logic fv;
      logic [NREQ-1:0] rdy, mask;

      reset = 1'b0; req_valid = '0; rsp_ready = '0; drain = 1'b0;
      for (int i = 0; i < NREQ; i++)
         set_req(i, {8'(i), 24'h0}, 32'h4000_0000 + 32'(i), 1'(i % 2), 2'(i));
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_fu_valid", 32'(fu_valid), 32'd0);
      check("rst_fu_opa", fu_opa, 32'd0);
      check("rst_idle", 32'(idle), 32'd1);
      tick();
      reset = 1'b1;

      // 1: single request, latency and idle
      set_req(0, 32'h3F80_0000, 32'h4000_0000, 1'b1, RM_NEAREST);
      req_valid = 4'b0001;
      @(negedge clk);
      check("t1_ready", 32'(req_ready), 32'h1);
      tick();
      req_valid = '0;
      @(negedge clk);
      check("t1_fu_valid", 32'(fu_valid), 32'd1);
      check("t1_fu_opa", fu_opa, 32'h3F80_0000);
      check("t1_fu_opb", fu_opb, 32'h4000_0000);
      check("t1_fu_add", 32'(fu_add), 32'd1);
      n = 0;
      while (!rsp_valid[0] && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t1_latency", 32'(n), 32'(LAT + 1));
      check("t1_data", rsp_data[31:0], 32'h4040_0000);
      check("t1_busy", 32'(idle), 32'd0);
      tick();
      rsp_ready = 4'b0001;
      tick();
      @(negedge clk);
      check("t1_idle", 32'(idle), 32'd1);
      check("t1_rsp_empty", 32'(rsp_valid), 32'd0);
      tick();

      // 2: fairness with everyone requesting
      rsp_ready = '1;
      req_valid = '1;
      exp_g = 1;
      for (int c = 0; c < 12; c++) begin
         step(g, fv, rdy);
         check("t2_rr_order", 32'(g), 32'(exp_g));
         if (c > 0) check("t2_fu_valid", 32'(fv), 32'd1);
         exp_g = (exp_g + 1) % NREQ;
      end
      req_valid = '0;
      wait_idle("t2_idle");

      // 3: backpressure on requester 1
      rsp_ready = 4'b1101;
      req_valid = '1;
      n1 = 0; others = 0;
      for (int c = 0; c < 14; c++) begin
         step(g, fv, rdy);
         if (n1 == 2) begin
            check("t3_req1_blocked", 32'(rdy[1]), 32'd0);
            if (g >= 0 && g != 1) others++;
         end
         if (g == 1) n1++;
      end
      check("t3_req1_grants", 32'(n1), 32'd2);
      check("t3_others_granted", 32'(others > 0), 32'd1);
      rsp_ready[1] = 1'b1;
      step(g, fv, rdy);
      check("t3_pop_cycle_no_grant", 32'(rdy[1]), 32'd0);
      rsp_ready[1] = 1'b0;
      n1 = 0;
      for (int c = 0; c < 12; c++) begin
         step(g, fv, rdy);
         if (g == 1) n1++;
      end
      check("t3_regrant_count", 32'(n1), 32'd1);
      req_valid = '0;
      rsp_ready = '1;
      wait_idle("t3_idle");

      // 4: pop and grant on requester 2 in the same edge at credit CRED-1
      rsp_ready = '0;
      req_valid = 4'b0100;
      step(g, fv, rdy);
      check("t4_first_grant", 32'(g), 32'd2);
      req_valid = '0;
      n = 0;
      @(negedge clk);
      while (!rsp_valid[2] && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t4_queued", 32'(rsp_valid[2]), 32'd1);
      tick();
      req_valid[2] = 1'b1;
      rsp_ready[2] = 1'b1;
      @(negedge clk);
      check("t4_ready_at_pop", 32'(req_ready[2]), 32'd1);
      check("t4_pop_pending", 32'(rsp_valid[2]), 32'd1);
      tick();
      req_opa[64 +: 32] = 32'h0200_0A01;
      @(negedge clk);
      check("t4_regrant", 32'(req_ready[2]), 32'd1);
      check("t4_q_empty", 32'(rsp_valid[2]), 32'd0);
      tick();
      req_opa[64 +: 32] = 32'h0200_0A02;
      @(negedge clk);
      check("t4_credit_full", 32'(req_ready[2]), 32'd0);
      tick();
      req_valid = '0;
      wait_idle("t4_idle");

      // 5: drain with three in flight
      rsp_ready = '1;
      req_valid = 4'b0111;
      mask = '0;
      for (int c = 0; c < 3; c++) begin
         step(g, fv, rdy);
         if (g >= 0) mask[g] = 1'b1;
      end
      check("t5_three_grants", 32'(mask), 32'h7);
      pops0 = n_pops;
      drain = 1'b1;
      @(negedge clk);
      check("t5_ready_blocked", 32'(req_ready), 32'd0);
      check("t5_last_issue", 32'(fu_valid), 32'd1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("t5_no_issue", 32'(fu_valid), 32'd0);
      end
      wait_idle("t5_idle");
      check("t5_delivered", 32'(n_pops - pops0), 32'd3);
      drain = 1'b0;
      req_valid = '0;

      // 6: reset with two in flight and one queued
      rsp_ready = '0;
      req_valid = 4'b0001;
      step(g, fv, rdy);
      check("t6_grant0", 32'(g), 32'd0);
      req_valid = '0;
      n = 0;
      @(negedge clk);
      while (!rsp_valid[0] && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t6_queued", 32'(rsp_valid[0]), 32'd1);
      tick();
      req_valid = 4'b0110;
      step(g, fv, rdy);
      step(g, fv, rdy);
      reset = 1'b0;
      req_valid = '0;
      @(negedge clk);
      check("t6_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("t6_rst_idle", 32'(idle), 32'd1);
      check("t6_rst_fu_valid", 32'(fu_valid), 32'd0);
      tick();
      reset = 1'b1;
      for (int c = 0; c < LAT + 4; c++) begin
         @(negedge clk);
         check("t6_no_stale_rsp", 32'(rsp_valid), 32'd0);
      end
      tick();
      req_valid = '1;
      @(negedge clk);
      check("t6_first_grant", 32'(req_ready), 32'h1);
      tick();
      req_valid = '0;
      rsp_ready = '1;
      wait_idle("t6_idle");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
